// File: rtl/debounce_pulse_bank.sv
// Multi-channel switch conditioner: 2-FF synchroniser, tick-paced debounce, rise/fall one-shots
// and optional auto-repeat pulses while a channel is held high.
module debounce_pulse_bank #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned TICK_DIV    = 1000000,
    parameter int unsigned STABLE_CNT  = 10,
    parameter int unsigned REPEAT_EN   = 0,
    parameter int unsigned REPEAT_DLY  = 50,
    parameter int unsigned REPEAT_RATE = 10
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [CHANNELS-1:0] d_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise_p,
    output logic [CHANNELS-1:0] fall_p,
    output logic [CHANNELS-1:0] rpt_p,
    output logic                tick
);

    localparam int unsigned DW   = $clog2(TICK_DIV);
    localparam int unsigned SW   = $clog2(STABLE_CNT + 1);
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DivMax    = DW'(TICK_DIV - 1);
    localparam logic [SW-1:0] StableMax = SW'(STABLE_CNT - 1);
    localparam logic [RW-1:0] DlyMax    = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] RateMax   = RW'(REPEAT_RATE - 1);

    logic [DW-1:0]                div_q, div_d;
    logic                         tick_q, tick_d;
    logic [CHANNELS-1:0]          sync1_q, sync2_q;
    logic [CHANNELS-1:0]          level_q, level_d;
    logic [CHANNELS-1:0]          rise_q, rise_d;
    logic [CHANNELS-1:0]          fall_q, fall_d;
    logic [CHANNELS-1:0]          rpt_q, rpt_d;
    logic [CHANNELS-1:0]          rep_q, rep_d;
    logic [CHANNELS-1:0][SW-1:0]  cnt_q, cnt_d;
    logic [CHANNELS-1:0][RW-1:0]  rcnt_q, rcnt_d;

    always_comb begin
        div_d   = (div_q == DivMax) ? '0 : div_q + 1'b1;
        tick_d  = (div_d == DivMax);
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        rpt_d   = '0;
        cnt_d   = cnt_q;
        rcnt_d  = rcnt_q;
        rep_d   = rep_q;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (tick_q) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == StableMax) begin
                        cnt_d[i]   = '0;
                        level_d[i] = sync2_q[i];
                        rise_d[i]  = sync2_q[i];
                        fall_d[i]  = ~sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
                // rep_q selects between the initial delay and the steady repeat period
                if (REPEAT_EN != 0 && level_q[i] && !fall_d[i]) begin
                    if (rcnt_q[i] == (rep_q[i] ? RateMax : DlyMax)) begin
                        rpt_d[i]  = 1'b1;
                        rcnt_d[i] = '0;
                        rep_d[i]  = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + 1'b1;
                    end
                end
            end
            if (!level_d[i]) begin
                rcnt_d[i] = '0;
                rep_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            tick_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            rpt_q   <= '0;
            rep_q   <= '0;
            cnt_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            div_q   <= div_d;
            tick_q  <= tick_d;
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rpt_q   <= rpt_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign level  = level_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;
    assign rpt_p  = rpt_q;
    assign tick   = tick_q;

endmodule
